sccb_write_arbiter: RTL and testbench

//  Shares one I2C/SCCB controller between N_REQ register-write requesters, e.g. boot LUT

---
 rtl/sccb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/sccb_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sccb_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB/I2C write arbiter: transfer word width,
// OV7670 write slave address and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package sccb_pkg;

    // One SCCB write is {slave_addr[7:0], sub_addr[7:0], data[7:0]}
    localparam int          SCCB_W       = 24;
    localparam logic [7:0]  OV7670_WADDR = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GO       = 3'd1,
        ST_WAIT_END = 3'd2,
        ST_WAIT_CLR = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request strictly after the
// pointer (wrapping) wins, so the requester at the pointer has lowest priority.
// Ports:
//   i_req   [N_REQ-1:0]  request vector
//   i_ptr   [2:0]        index of the requester served last
//   o_grant [N_REQ-1:0]  one-hot grant (all zero when no request)
//   o_idx   [2:0]        index of the granted requester
//   o_any                at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [2:0]       o_idx,
    output logic             o_any
);

    logic [7:0] w_req8;

    always_comb begin
        logic [3:0] w_cand;
        w_req8             = '0;
        w_req8[N_REQ-1:0]  = i_req;
        o_idx              = '0;
        o_any              = 1'b0;
        w_cand             = '0;
        // Walk ptr+1 .. ptr+N_REQ modulo N_REQ; first hit wins
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = {1'b0, i_ptr} + 4'(i);
            if (w_cand >= 4'(N_REQ))
                w_cand = w_cand - 4'(N_REQ);
            if (!o_any && w_req8[w_cand[2:0]]) begin
                o_any = 1'b1;
                o_idx = w_cand[2:0];
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N_REQ; j++)
            o_grant[j] = o_any && (o_idx == 3'(j));
    end

endmodule

// File: rtl/sccb_write_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_write_arbiter
// Shares one SCCB/I2C controller between N_REQ register-write requesters.
// Round-robin grant, GO/END/ACK handshake with the controller, NACK retry
// (MAX_RETRY extra attempts) and a GO-to-END timeout.
// Ports:
//   iCLK, iRST_N           clock, async active-low reset
//   req      [N_REQ]       level requests, held until own done/err pulse
//   req_data [24*N_REQ]    per-requester {slave,sub,data}, slice k = [24k+:24]
//   done/err [N_REQ]       one-cycle completion pulses per requester
//   i2c_data [24], i2c_go  word and GO level to the controller
//   i2c_end, i2c_ack       controller END (asynchronous) and ACK (0 = ACKed)
//   busy                   transfer in progress (GRANT through RESP)
//   grant_id [3]           current/last granted requester
// -----------------------------------------------------------------------------
module sccb_write_arbiter
    import sccb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [N_REQ-1:0]        req,
    input  logic [SCCB_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [SCCB_W-1:0]       i2c_data,
    output logic                    i2c_go,
    input  logic                    i2c_end,
    input  logic                    i2c_ack,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    localparam int              RC_W      = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [RC_W-1:0] RETRY_MAX = RC_W'(MAX_RETRY);
    localparam logic [31:0]     TMO_LAST  = 32'(TIMEOUT_CYC - 1);

    state_t            r_state, w_next;
    logic              r_end_meta, r_end_s;
    logic [N_REQ-1:0]  w_gnt, w_k_oh;
    logic [2:0]        w_idx;
    logic              w_any;
    logic [SCCB_W-1:0] w_sel, r_data;
    logic [2:0]        r_k, r_ptr;
    logic [RC_W-1:0]   r_retry;
    logic [31:0]       r_tmo;
    logic              r_timeout, r_ack, r_go;
    logic [N_REQ-1:0]  r_done, r_err;
    logic              w_ok, w_fail, w_retry;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_gnt[i]) w_sel = req_data[i*SCCB_W +: SCCB_W];
    end

    always_comb begin
        w_k_oh = '0;
        for (int i = 0; i < N_REQ; i++)
            w_k_oh[i] = (r_k == 3'(i));
    end

    // END comes from another timing domain; ACK is only looked at once the
    // synchronised END is high, by which time it has long been stable.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_end_meta <= 1'b0;
            r_end_s    <= 1'b0;
        end else begin
            r_end_meta <= i2c_end;
            r_end_s    <= r_end_meta;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ok    = 1'b0;
        w_fail  = 1'b0;
        w_retry = 1'b0;
        case (r_state)
            ST_IDLE:     if (w_any) w_next = ST_GO;
            ST_GO:       w_next = ST_WAIT_END;
            // END wins over a same-cycle timeout
            ST_WAIT_END: if (r_end_s || r_tmo == TMO_LAST) w_next = ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                if (!r_end_s) begin
                    if (r_timeout) begin
                        w_fail = 1'b1;
                        w_next = ST_RESP;
                    end else if (!r_ack) begin
                        w_ok   = 1'b1;
                        w_next = ST_RESP;
                    end else if (r_retry < RETRY_MAX) begin
                        w_retry = 1'b1;
                        w_next  = ST_GO;
                    end else begin
                        w_fail = 1'b1;
                        w_next = ST_RESP;
                    end
                end
            end
            ST_RESP:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_data    <= '0;
            r_k       <= '0;
            r_ptr     <= 3'(N_REQ - 1);
            r_retry   <= '0;
            r_tmo     <= '0;
            r_timeout <= 1'b0;
            r_ack     <= 1'b0;
            r_go      <= 1'b0;
            r_done    <= '0;
            r_err     <= '0;
        end else begin
            // GO is high exactly while waiting for END
            r_go   <= (w_next == ST_WAIT_END);
            r_done <= w_ok   ? w_k_oh : '0;
            r_err  <= w_fail ? w_k_oh : '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_k     <= w_idx;
                        r_data  <= w_sel;
                        r_retry <= '0;
                    end
                end
                ST_GO: begin
                    r_tmo     <= '0;
                    r_timeout <= 1'b0;
                end
                ST_WAIT_END: begin
                    if (r_tmo != '1) r_tmo <= r_tmo + 32'd1;
                    if (r_end_s)                r_ack     <= i2c_ack;
                    else if (r_tmo == TMO_LAST) r_timeout <= 1'b1;
                end
                ST_WAIT_CLR: if (w_retry) r_retry <= r_retry + 1'b1;
                ST_RESP:     r_ptr <= r_k;
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign i2c_data = r_data;
    assign i2c_go   = r_go;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_k;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
module tb_sccb_write_arbiter;

    localparam int N   = 2;
    localparam int MR  = 3;
    localparam int TMO = 1000;

    logic          iCLK = 1'b0;
    logic          iRST_N;
    logic [N-1:0]  req;
    logic [24*N-1:0] req_data;
    logic [N-1:0]  done, err;
    logic [23:0]   i2c_data;
    logic          i2c_go;
    logic          i2c_end, i2c_ack;
    logic          busy;
    logic [2:0]    grant_id;

    sccb_write_arbiter #(.N_REQ(N), .MAX_RETRY(MR), .TIMEOUT_CYC(TMO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .req(req), .req_data(req_data),
        .done(done), .err(err), .i2c_data(i2c_data), .i2c_go(i2c_go),
        .i2c_end(i2c_end), .i2c_ack(i2c_ack), .busy(busy), .grant_id(grant_id)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    // observation log, filled by step()
    int          cyc, go_cnt, go_rise, go_fall, multi, unstable;
    logic [23:0] go_data_q[$];
    int          ev_q[$];          // requester index, +8 when it was an err pulse
    bit          go_prev;
    logic [23:0] data_prev;

    // controller model knobs
    bit hang;
    int lat_min, lat_max;
    bit ack_q[$];

    // reference: requester served last
    int last_srv;

    // Behavioural controller: after GO, wait a latency, raise END with the next
    // scripted ACK, hold until GO drops, then release END a little later.
    initial begin
        i2c_end = 1'b0;
        i2c_ack = 1'b0;
        forever begin
            wait (i2c_go === 1'b1);
            if (hang) begin
                wait (i2c_go === 1'b0);
            end else begin
                repeat ($urandom_range(lat_max, lat_min)) @(posedge iCLK);
                @(negedge iCLK);
                i2c_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                i2c_end = 1'b1;
                wait (i2c_go === 1'b0);
                repeat ($urandom_range(3, 1)) @(negedge iCLK);
                i2c_end = 1'b0;
                i2c_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic int ev_at(int i);
        return (i < ev_q.size()) ? ev_q[i] : -1;
    endfunction

    function automatic logic [23:0] god_at(int i);
        return (i < go_data_q.size()) ? go_data_q[i] : 24'hxxxxxx;
    endfunction

    // One cycle: sample at negedge, log GO edges and pulses, requester drops
    // its req the cycle after its own pulse.
    task automatic step();
        @(negedge iCLK);
        cyc++;
        if (i2c_go && !go_prev) begin
            go_cnt++;
            go_data_q.push_back(i2c_data);
            go_rise = cyc;
        end
        if (!i2c_go && go_prev) go_fall = cyc;
        if (i2c_go && go_prev && i2c_data !== data_prev) unstable++;
        go_prev   = i2c_go;
        data_prev = i2c_data;
        if ((done & err) != '0 || $countones({done, err}) > 1) multi++;
        for (int k = 0; k < N; k++) begin
            if (done[k]) begin ev_q.push_back(k);     req[k] = 1'b0; end
            if (err[k])  begin ev_q.push_back(k + 8); req[k] = 1'b0; end
        end
    endtask

    task automatic clear_logs();
        go_cnt = 0; go_rise = 0; go_fall = 0; multi = 0; unstable = 0;
        go_data_q.delete();
        ev_q.delete();
    endtask

    task automatic run_until(input int n, input int bound, input string nm);
        int t = 0;
        while (ev_q.size() < n && t < bound) begin
            step();
            t++;
        end
        checks++;
        if (ev_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d responses, required %0d within %0d cycles", nm, ev_q.size(), n, bound);
        end
        repeat (8) step();
    endtask

    task automatic wait_go(input int bound, input string nm);
        int t = 0;
        while (go_cnt == 0 && t < bound) begin
            step();
            t++;
        end
        checks++;
        if (go_cnt == 0) begin
            errors++;
            $display("FAIL %s_go: no GO within %0d cycles", nm, bound);
        end
    endtask

    task automatic do_reset();
        iRST_N   = 1'b0;
        req      = '0;
        req_data = '0;
        hang     = 1'b0;
        lat_min  = 2;
        lat_max  = 30;
        ack_q.delete();
        repeat (3) step();
        iRST_N = 1'b1;
        step();
        clear_logs();
        last_srv = N - 1;
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        req = '1;
        req_data = {24'h123456, 24'h654321};
        repeat (3) step();
        checks++; if (i2c_go !== 1'b0)   begin errors++; $display("FAIL reset_go: got %b required 0", i2c_go); end
        checks++; if (i2c_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h required 000000", i2c_data); end
        checks++; if (done !== '0)       begin errors++; $display("FAIL reset_done: got %b required 00", done); end
        checks++; if (err !== '0)        begin errors++; $display("FAIL reset_err: got %b required 00", err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid: got %0d required 0", grant_id); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        lat_min = 500; lat_max = 500;
        req_data[23:0] = 24'h421214;
        req = 2'b01;
        wait_go(20, "single");
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL single_gid: got %0d required 0", grant_id); end
        run_until(1, 2000, "single");
        checks++; if (go_cnt != 1)       begin errors++; $display("FAIL single_gocnt: got %0d required 1", go_cnt); end
        checks++; if (god_at(0) !== 24'h421214) begin errors++; $display("FAIL single_data: got %h required 421214", god_at(0)); end
        checks++; if (ev_q.size() != 1 || ev_at(0) != 0) begin errors++; $display("FAIL single_resp: got %0d responses first=%0d required one done[0]", ev_q.size(), ev_at(0)); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL single_idle: got busy=%b required 0", busy); end
    endtask

    task automatic test_contention();
        do_reset();
        req_data = {24'h4201AA, 24'h420255};
        req = 2'b11;
        run_until(2, 2000, "contend");
        checks++; if (ev_at(0) != 0 || ev_at(1) != 1) begin errors++; $display("FAIL contend_order: got %0d,%0d required 0,1", ev_at(0), ev_at(1)); end
        checks++; if (ev_q.size() != 2) begin errors++; $display("FAIL contend_count: got %0d required 2", ev_q.size()); end
        checks++; if (multi != 0)       begin errors++; $display("FAIL contend_overlap: got %0d overlapping pulse cycles required 0", multi); end
        checks++; if (god_at(0) !== 24'h420255 || god_at(1) !== 24'h4201AA) begin errors++; $display("FAIL contend_data: got %h,%h required 420255,4201aa", god_at(0), god_at(1)); end
        checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL contend_gid: got %0d required 1", grant_id); end
    endtask

    task automatic test_nack();
        logic [23:0] d;
        do_reset();
        d = {8'h42, 16'($urandom)};
        ack_q.push_back(1'b1); ack_q.push_back(1'b1); ack_q.push_back(1'b0);
        req_data[23:0] = d;
        req = 2'b01;
        wait_go(20, "nack");
        req_data[23:0] = ~d;   // must be ignored after grant
        run_until(1, 3000, "nack");
        checks++; if (go_cnt != 3) begin errors++; $display("FAIL nack_gocnt: got %0d required 3", go_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (god_at(i) !== d) begin errors++; $display("FAIL nack_data%0d: got %h required %h", i, god_at(i), d); end
        end
        checks++; if (ev_q.size() != 1 || ev_at(0) != 0) begin errors++; $display("FAIL nack_resp: got %0d responses first=%0d required one done[0]", ev_q.size(), ev_at(0)); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL nack_stable: got %0d data changes under GO required 0", unstable); end
    endtask

    task automatic test_exhausted();
        do_reset();
        repeat (MR + 1) ack_q.push_back(1'b1);
        ack_q.push_back(1'b0);  // an extra attempt would wrongly succeed
        req_data[23:0] = 24'h420A0B;
        req = 2'b01;
        run_until(1, 4000, "exhaust");
        checks++; if (go_cnt != MR + 1) begin errors++; $display("FAIL exhaust_gocnt: got %0d required %0d", go_cnt, MR + 1); end
        checks++; if (ev_q.size() != 1 || ev_at(0) != 8) begin errors++; $display("FAIL exhaust_resp: got %0d responses first=%0d required one err[0]", ev_q.size(), ev_at(0)); end
        ack_q.delete();
    endtask

    task automatic test_timeout();
        do_reset();
        hang = 1'b1;
        req_data[47:24] = 24'h420C0D;
        req = 2'b10;
        run_until(1, TMO + 100, "timeout");
        checks++; if (go_fall - go_rise != TMO) begin errors++; $display("FAIL timeout_len: got GO high %0d cycles required %0d", go_fall - go_rise, TMO); end
        checks++; if (go_cnt != 1) begin errors++; $display("FAIL timeout_gocnt: got %0d required 1", go_cnt); end
        checks++; if (ev_q.size() != 1 || ev_at(0) != 9) begin errors++; $display("FAIL timeout_resp: got %0d responses first=%0d required one err[1]", ev_q.size(), ev_at(0)); end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        hang = 1'b1;
        req_data = {24'h421111, 24'h422222};
        req = 2'b01;
        wait_go(20, "rstmid");
        repeat (10) step();
        #1 iRST_N = 1'b0;
        #1;
        checks++; if (i2c_go !== 1'b0) begin errors++; $display("FAIL rstmid_go: got %b required 0", i2c_go); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        repeat (5) step();
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rstmid_pulse: got %0d responses required 0", ev_q.size()); end
        hang = 1'b0;
        iRST_N = 1'b1;
        clear_logs();
        last_srv = N - 1;
        req = 2'b11;
        run_until(2, 2000, "rstmid");
        checks++; if (ev_at(0) != 0 || ev_at(1) != 1) begin errors++; $display("FAIL rstmid_rearb: got %0d,%0d required 0,1", ev_at(0), ev_at(1)); end
        checks++; if (god_at(0) !== 24'h422222 || god_at(1) !== 24'h421111) begin errors++; $display("FAIL rstmid_data: got %h,%h required 422222,421111", god_at(0), god_at(1)); end
    endtask

    // Random rounds: reference picks the service order from the last-served
    // requester and derives attempts/outcome from the scripted NACK count.
    task automatic test_random();
        do_reset();
        for (int r = 0; r < 14; r++) begin
            int          mask;
            int          nk[N];
            logic [23:0] d[N];
            int          order[$];
            int          exp_ev[$];
            logic [23:0] exp_go[$];
            mask = $urandom_range(3, 1);
            for (int k = 0; k < N; k++) begin
                d[k]  = {8'h42, 16'($urandom)};
                nk[k] = $urandom_range(MR + 1, 0);
            end
            for (int i = 1; i <= N; i++) begin
                int c = (last_srv + i) % N;
                if (mask[c]) order.push_back(c);
            end
            foreach (order[j]) begin
                int k = order[j];
                int att = (nk[k] <= MR) ? nk[k] + 1 : MR + 1;
                repeat (att) exp_go.push_back(d[k]);
                repeat (att - ((nk[k] <= MR) ? 1 : 0)) ack_q.push_back(1'b1);
                if (nk[k] <= MR) ack_q.push_back(1'b0);
                exp_ev.push_back((nk[k] <= MR) ? k : k + 8);
            end
            clear_logs();
            req_data = {d[1], d[0]};
            req = mask[N-1:0];
            run_until(order.size(), 4000, "rand");
            checks++; if (ev_q.size() != exp_ev.size()) begin errors++; $display("FAIL rand%0d_count: got %0d responses required %0d", r, ev_q.size(), exp_ev.size()); end
            foreach (exp_ev[j]) begin
                checks++; if (ev_at(j) != exp_ev[j]) begin errors++; $display("FAIL rand%0d_ev%0d: got %0d required %0d", r, j, ev_at(j), exp_ev[j]); end
            end
            checks++; if (go_cnt != exp_go.size()) begin errors++; $display("FAIL rand%0d_gocnt: got %0d required %0d", r, go_cnt, exp_go.size()); end
            foreach (exp_go[j]) begin
                checks++; if (god_at(j) !== exp_go[j]) begin errors++; $display("FAIL rand%0d_data%0d: got %h required %h", r, j, god_at(j), exp_go[j]); end
            end
            checks++; if (grant_id !== 3'(order[order.size()-1])) begin errors++; $display("FAIL rand%0d_gid: got %0d required %0d", r, grant_id, order[order.size()-1]); end
            checks++; if (multi != 0 || unstable != 0) begin errors++; $display("FAIL rand%0d_proto: got overlap=%0d unstable=%0d required 0,0", r, multi, unstable); end
            last_srv = order[order.size()-1];
            ack_q.delete();
        end
    endtask

    initial begin
        cyc = 0; go_prev = 1'b0; data_prev = '0;
        hang = 1'b0; lat_min = 2; lat_max = 30;
        clear_logs();
        test_reset();
        test_single();
        test_contention();
        test_nack();
        test_exhausted();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
